mem_access_stage: RTL and testbench

Memory-access stage between the EX/MEM pipeline register and the MEM/WB register. It accepts one instruction per cycle from EX/MEM, performs stores into an internal data memory, and services loads with a parameterised multi-cycle read latency. While a load is in flight it stalls upstream. It delivers exactly one registered result (or bubble) per issued instruction to MEM/WB, which selects the writeback source from `read_enable_out`.

---
 rtl/mem_access_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage.
// Stores complete in one cycle. Loads stall upstream for MEM_LATENCY cycles and
// then return the data. Each issued instruction produces exactly one registered
// result or bubble toward MEM/WB.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | sampling EX/MEM every cycle; non-loads pass through in 1 cycle
// READ_WAIT | load captured; cnt counts down the remaining wait cycles,
//           | and the data is returned on the edge where cnt == 0
module mem_access_stage #(
  parameter int DATA_W      = 24,
  parameter int DEST_W      = 4,
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk_a,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              writeback_enable,
  input  logic              read_enable,
  input  logic              write_enable,
  input  logic [DEST_W-1:0] instruction_dest,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data_a,
  output logic              stall_out,
  output logic              writeback_enable_out,
  output logic              read_enable_out,
  output logic [DEST_W-1:0] instruction_dest_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] read_data_out
);

  localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE      = 1'b0,
    READ_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Fields of the load held while the memory is being waited on.
  logic [DEST_W-1:0] hold_dest_q, hold_dest_d;
  logic              hold_wb_q, hold_wb_d;
  logic [DATA_W-1:0] hold_alu_q, hold_alu_d;

  // Registered MEM/WB outputs.
  logic              wb_out_q, wb_out_d;
  logic              re_out_q, re_out_d;
  logic [DEST_W-1:0] dest_out_q, dest_out_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d;
  logic [DATA_W-1:0] rdata_out_q, rdata_out_d;

  logic              stall_c;
  logic              mem_we;
  logic [ADDR_W-1:0] in_addr;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] mem_rdata;

  // Data memory is deliberately not reset; its contents survive rst.
  logic [DATA_W-1:0] data_mem [MEM_DEPTH];

  // Only the low address bits select a word, so addresses wrap.
  assign in_addr   = alu_result[ADDR_W-1:0];
  assign hold_addr = hold_alu_q[ADDR_W-1:0];
  assign mem_rdata = data_mem[hold_addr];

  // Stall is suppressed while in reset so upstream is never frozen by it.
  assign stall_out = stall_c & ~rst;

  // Next-state, hold capture, output formation and store/stall decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_dest_d = hold_dest_q;
    hold_wb_d   = hold_wb_q;
    hold_alu_d  = hold_alu_q;
    wb_out_d    = 1'b0;
    re_out_d    = 1'b0;
    dest_out_d  = '0;
    alu_out_d   = '0;
    rdata_out_d = '0;
    stall_c     = 1'b0;
    mem_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          mem_we = write_enable;
          if (read_enable) begin
            // Capture the load. A store in the same instruction is
            // committed on this edge, so the load sees the new data.
            stall_c     = 1'b1;
            hold_dest_d = instruction_dest;
            hold_wb_d   = writeback_enable;
            hold_alu_d  = alu_result;
            cnt_d       = CNT_LOAD;
            state_d     = READ_WAIT;
          end else begin
            wb_out_d   = writeback_enable;
            dest_out_d = instruction_dest;
            alu_out_d  = alu_result;
          end
        end
      end

      READ_WAIT: begin
        if (cnt_q != CNT_ZERO) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_ONE;
        end else begin
          // Final edge: the held inputs are consumed here and the load retires.
          wb_out_d    = hold_wb_q;
          re_out_d    = 1'b1;
          dest_out_d  = hold_dest_q;
          alu_out_d   = hold_alu_q;
          rdata_out_d = mem_rdata;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, held-load and output registers with synchronous reset.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_dest_q <= '0;
      hold_wb_q   <= 1'b0;
      hold_alu_q  <= '0;
      wb_out_q    <= 1'b0;
      re_out_q    <= 1'b0;
      dest_out_q  <= '0;
      alu_out_q   <= '0;
      rdata_out_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_dest_q <= hold_dest_d;
      hold_wb_q   <= hold_wb_d;
      hold_alu_q  <= hold_alu_d;
      wb_out_q    <= wb_out_d;
      re_out_q    <= re_out_d;
      dest_out_q  <= dest_out_d;
      alu_out_q   <= alu_out_d;
      rdata_out_q <= rdata_out_d;
    end
  end

  // Store port; writes are blocked during reset.
  always_ff @(posedge clk_a) begin
    if (mem_we && !rst) begin
      data_mem[in_addr] <= write_data_a;
    end
  end

  assign writeback_enable_out = wb_out_q;
  assign read_enable_out      = re_out_q;
  assign instruction_dest_out = dest_out_q;
  assign alu_result_out       = alu_out_q;
  assign read_data_out        = rdata_out_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: randomized instruction stream against a
// behavioural model, plus directed scenarios with literal expectations.
module tb_mem_access_stage;

  localparam int DATA_W  = 24;
  localparam int DEST_W  = 4;
  localparam int ADDR_W  = 8;
  localparam int MEM_LAT = 2;

  logic              clk_a = 1'b0;
  logic              rst;
  logic              valid_in, writeback_enable, read_enable, write_enable;
  logic [DEST_W-1:0] instruction_dest;
  logic [DATA_W-1:0] alu_result, write_data_a;
  logic              stall_out, writeback_enable_out, read_enable_out;
  logic [DEST_W-1:0] instruction_dest_out;
  logic [DATA_W-1:0] alu_result_out, read_data_out;

  mem_access_stage #(
    .DATA_W(DATA_W), .DEST_W(DEST_W), .ADDR_W(ADDR_W), .MEM_LATENCY(MEM_LAT)
  ) dut (
    .clk_a                (clk_a),
    .rst                  (rst),
    .valid_in             (valid_in),
    .writeback_enable     (writeback_enable),
    .read_enable          (read_enable),
    .write_enable         (write_enable),
    .instruction_dest     (instruction_dest),
    .alu_result           (alu_result),
    .write_data_a         (write_data_a),
    .stall_out            (stall_out),
    .writeback_enable_out (writeback_enable_out),
    .read_enable_out      (read_enable_out),
    .instruction_dest_out (instruction_dest_out),
    .alu_result_out       (alu_result_out),
    .read_data_out        (read_data_out)
  );

  always #5 clk_a = ~clk_a;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory array, plus "a load accepted in cycle k
  // retires on the edge ending cycle k+MEM_LAT".
  logic [DATA_W-1:0] m_mem [1 << ADDR_W];
  int                cyc = 0;
  bit                m_busy = 0;
  int                m_done_cyc = 0;
  logic [DEST_W-1:0] h_dest;
  logic              h_wb;
  logic [DATA_W-1:0] h_alu;

  logic              exp_stall = 1'b0;
  logic              e_wb = 1'b0, e_re = 1'b0;
  logic [DEST_W-1:0] e_dest = '0;
  logic [DATA_W-1:0] e_alu = '0, e_rdata = '0;

  bit chk_en = 0;
  int stall_hi_cnt = 0;

  function automatic logic m_stall();
    if (rst) return 1'b0;
    if (m_busy) return (cyc < m_done_cyc);
    return valid_in && read_enable;
  endfunction

  task automatic bubble();
    e_wb = 0; e_re = 0; e_dest = '0; e_alu = '0; e_rdata = '0;
  endtask

  task automatic model_edge();
    if (rst) begin
      bubble();
      m_busy = 0;
    end else if (m_busy) begin
      if (cyc == m_done_cyc) begin
        e_wb = h_wb; e_re = 1; e_dest = h_dest; e_alu = h_alu;
        e_rdata = m_mem[h_alu[ADDR_W-1:0]];
        m_busy = 0;
      end else begin
        bubble();
      end
    end else if (!valid_in) begin
      bubble();
    end else begin
      if (write_enable) m_mem[alu_result[ADDR_W-1:0]] = write_data_a;
      if (read_enable) begin
        m_busy = 1;
        m_done_cyc = cyc + MEM_LAT;
        h_dest = instruction_dest; h_wb = writeback_enable; h_alu = alu_result;
        bubble();
      end else begin
        e_wb = writeback_enable; e_re = 0; e_dest = instruction_dest;
        e_alu = alu_result; e_rdata = '0;
      end
    end
    cyc++;
  endtask

  // Single compare process: DUT against the model every cycle.
  always @(negedge clk_a) begin
    if (chk_en) begin
      chk("stall_out", 32'(stall_out), 32'(exp_stall));
      chk("wb_out", 32'(writeback_enable_out), 32'(e_wb));
      chk("re_out", 32'(read_enable_out), 32'(e_re));
      chk("dest_out", 32'(instruction_dest_out), 32'(e_dest));
      chk("alu_out", 32'(alu_result_out), 32'(e_alu));
      chk("rdata_out", 32'(read_data_out), 32'(e_rdata));
      if (stall_out) stall_hi_cnt++;
    end
  end

  task automatic drive(input logic v, input logic wb, input logic re, input logic we,
                       input logic [DEST_W-1:0] d, input logic [DATA_W-1:0] alu,
                       input logic [DATA_W-1:0] wd);
    valid_in = v; writeback_enable = wb; read_enable = re; write_enable = we;
    instruction_dest = d; alu_result = alu; write_data_a = wd;
  endtask

  task automatic step();
    exp_stall = m_stall();
    @(negedge clk_a);
    @(posedge clk_a);
    model_edge();
    #1;
  endtask

  // Present one instruction and hold it until the stage consumes it.
  task automatic issue(input logic v, input logic wb, input logic re, input logic we,
                       input logic [DEST_W-1:0] d, input logic [DATA_W-1:0] alu,
                       input logic [DATA_W-1:0] wd);
    int guard;
    drive(v, wb, re, we, d, alu, wd);
    step();
    guard = 0;
    while (m_busy && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) begin
      failures++;
      $display("FAIL load_timeout: load not retired within 50 cycles");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, '0, '0, '0);
    step();
    chk_en = 1;
    step();
    rst = 1'b0;

    // Fill memory with known data: word a holds 0x100000 | a.
    for (int a = 0; a < (1 << ADDR_W); a++)
      issue(1, a[0], 0, 1, a[3:0], DATA_W'(a), 24'h100000 | DATA_W'(a));

    // Reset with a load presented: no stall, outputs cleared.
    rst = 1'b1;
    drive(1, 1, 1, 0, 4'd6, 24'h000040, '0);
    step();
    step();
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_wb_out", 32'(writeback_enable_out), 32'd0);
    chk("rst_alu_out", 32'(alu_result_out), 32'd0);
    rst = 1'b0;
    issue(1, 1, 1, 0, 4'd6, 24'h000040, '0);
    chk("post_rst_load_data", 32'(read_data_out), 32'h100040);
    chk("post_rst_load_dest", 32'(instruction_dest_out), 32'd6);

    // ALU pass-through.
    issue(1, 1, 0, 0, 4'd1, 24'd1, '0);
    chk("alu_wb", 32'(writeback_enable_out), 32'd1);
    chk("alu_dest", 32'(instruction_dest_out), 32'd1);
    chk("alu_res", 32'(alu_result_out), 32'd1);
    chk("alu_re", 32'(read_enable_out), 32'd0);

    // Store then load, with stall count and single-cycle result.
    issue(1, 0, 0, 1, 4'd0, 24'd5, 24'hABCDEF);
    stall_hi_cnt = 0;
    issue(1, 1, 1, 0, 4'd2, 24'd5, '0);
    chk("load_stall_cycles", 32'(stall_hi_cnt), 32'd2);
    chk("load_data", 32'(read_data_out), 32'hABCDEF);
    chk("load_dest", 32'(instruction_dest_out), 32'd2);
    chk("load_re", 32'(read_enable_out), 32'd1);
    issue(0, 0, 0, 0, '0, '0, '0);
    chk("load_re_once", 32'(read_enable_out), 32'd0);

    // Simultaneous read and write returns the new data.
    issue(1, 1, 1, 1, 4'd3, 24'd2, 24'd7);
    chk("rw_same_data", 32'(read_data_out), 32'd7);

    // Address wrap.
    issue(1, 0, 0, 1, 4'd0, 24'h000103, 24'd9);
    issue(1, 1, 1, 0, 4'd4, 24'h000003, '0);
    chk("wrap_data", 32'(read_data_out), 32'd9);

    // Reset in the first READ_WAIT cycle abandons the load.
    drive(1, 1, 1, 0, 4'd7, 24'h000010, '0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, '0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("abandon_re", 32'(read_enable_out), 32'd0);
      chk("abandon_stall", 32'(stall_out), 32'd0);
    end
    issue(1, 1, 0, 0, 4'd9, 24'h123456, '0);
    chk("after_abandon_wb", 32'(writeback_enable_out), 32'd1);
    chk("after_abandon_dest", 32'(instruction_dest_out), 32'd9);
    chk("after_abandon_alu", 32'(alu_result_out), 32'h123456);

    // Randomized stream, occasional reset.
    for (int i = 0; i < 600; i++) begin
      logic [DATA_W-1:0] ra;
      ra = DATA_W'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              DEST_W'($urandom), ra, DATA_W'($urandom));
        step();
        rst = 1'b0;
      end else begin
        issue($urandom_range(0, 99) < 85, 1'($urandom), $urandom_range(0, 99) < 35,
              $urandom_range(0, 99) < 35, DEST_W'($urandom), ra, DATA_W'($urandom));
      end
    end
    drive(0, 0, 0, 0, '0, '0, '0);
    step();
    step();
    chk_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
